vend_ctrl: RTL and testbench

Parametrised vending-machine controller, successor to the fixed 4-select machine. It accepts coin pulses, accumulates credit with a ceiling, and validates a product select against a per-product price table. It dispenses over a valid/ready handshake, then returns change one coin at a time over a second handshake. It sits between the debounced button/coin front-end and the 7-segment display controller, which shows credit and price.

---
 rtl/vm_pkg.sv | 25 ++
 rtl/vend_ctrl_if.sv | 31 +++
 rtl/vm_change_sel.sv | 22 ++
 rtl/vend_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vend_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared coin encodings, coin values and controller state for the vending controller.
package vm_pkg;

  localparam logic [1:0] COIN_5   = 2'd0;
  localparam logic [1:0] COIN_10  = 2'd1;
  localparam logic [1:0] COIN_25  = 2'd2;
  localparam logic [1:0] COIN_100 = 2'd3;

  localparam int unsigned VAL_5   = 5;
  localparam int unsigned VAL_10  = 10;
  localparam int unsigned VAL_25  = 25;
  localparam int unsigned VAL_100 = 100;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} vm_state_e;

  function automatic logic [6:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  return 7'(VAL_5);
      COIN_10: return 7'(VAL_10);
      COIN_25: return 7'(VAL_25);
      default: return 7'(VAL_100);
    endcase
  endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Front-end <-> controller signal bundle. master = button/coin/dispenser side, slave = controller.
interface vend_ctrl_if #(
  parameter int SEL_W    = 4,
  parameter int CREDIT_W = 8
) ();
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                coin_reject;
  logic                select_valid;
  logic [SEL_W-1:0]    select;
  logic                cancel;
  logic                dispense_valid;
  logic [SEL_W-1:0]    dispense_id;
  logic                dispense_ready;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic                change_ready;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] price;
  logic                sold_out;

  modport master (
    output coin_valid, coin_type, select_valid, select, cancel, dispense_ready, change_ready,
    input  coin_reject, dispense_valid, dispense_id, change_valid, change_coin, credit, price, sold_out
  );

  modport slave (
    input  coin_valid, coin_type, select_valid, select, cancel, dispense_ready, change_ready,
    output coin_reject, dispense_valid, dispense_id, change_valid, change_coin, credit, price, sold_out
  );
endinterface

// File: rtl/vm_change_sel.sv
// Greedy change picker: largest of 25c/10c/5c not exceeding the given credit.
module vm_change_sel
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [CREDIT_W-1:0] value
);
  always_comb begin
    coin  = COIN_5;
    value = CREDIT_W'(VAL_5);
    if (credit >= CREDIT_W'(VAL_25)) begin
      coin  = COIN_25;
      value = CREDIT_W'(VAL_25);
    end else if (credit >= CREDIT_W'(VAL_10)) begin
      coin  = COIN_10;
      value = CREDIT_W'(VAL_10);
    end
  end
endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, select/price check, dispense and greedy change handshakes.
// Define VM_STOCK_EN to enable per-product stock counters and the sold_out pulse.
module vend_ctrl
  import vm_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W        = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 200,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_TABLE = {8'd125, 8'd100, 8'd75, 8'd50},
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 5
) (
  input logic        clk,
  input logic        reset,
  vend_ctrl_if.slave bus
);

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sold_out_q, sold_out_d;
  logic                dispense_valid_q, dispense_valid_d;
  logic [SEL_W-1:0]    dispense_id_q, dispense_id_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_coin_q, change_coin_d;
  logic [CREDIT_W-1:0] change_val_q, change_val_d;

  logic                sel_ok, coin_ok, stock_empty;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W:0]   coin_sum;
  logic [1:0]          pick_coin;
  logic [CREDIT_W-1:0] pick_val;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] s);
    price_of = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++)
      if (int'(s) == i) price_of = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
  endfunction

  assign sel_ok    = bus.select_valid && (int'(bus.select) < NUM_PRODUCTS);
  assign sel_price = price_of(bus.select);
  assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(bus.coin_type));

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    price_d          = price_q;
    dispense_valid_d = dispense_valid_q;
    dispense_id_d    = dispense_id_q;
    change_valid_d   = change_valid_q;
    coin_reject_d    = 1'b0;
    sold_out_d       = 1'b0;
    coin_ok          = 1'b1;
    case (state_q)
      IDLE, CREDIT: begin
        // cancel beats select beats coin; a taken cancel/select swallows the coin
        if (bus.cancel && state_q == CREDIT) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          coin_ok        = 1'b0;
        end else if (sel_ok) begin
          price_d = sel_price;
          if (stock_empty) begin
            sold_out_d = 1'b1;
          end else if (credit_q >= sel_price) begin
            state_d          = VEND;
            dispense_valid_d = 1'b1;
            dispense_id_d    = bus.select;
            coin_ok          = 1'b0;
          end
        end
        if (bus.coin_valid) begin
          if (coin_ok && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_d = bus.coin_valid;
        if (bus.dispense_ready) begin
          dispense_valid_d = 1'b0;
          credit_d         = credit_q - price_q;
          if (credit_d != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE: begin
        coin_reject_d = bus.coin_valid;
        if (bus.change_ready) begin
          credit_d = credit_q - change_val_q;
          if (credit_d == '0) begin
            state_d        = IDLE;
            change_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Picker sees next-cycle credit so the registered coin always matches the registered credit.
  vm_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit (credit_d),
    .coin   (pick_coin),
    .value  (pick_val)
  );

  always_comb begin
    change_coin_d = change_coin_q;
    change_val_d  = change_val_q;
    if (change_valid_d) begin
      change_coin_d = pick_coin;
      change_val_d  = pick_val;
    end
  end

`ifdef VM_STOCK_EN
  logic [NUM_PRODUCTS-1:0][STOCK_W-1:0] stock_q, stock_d;
  logic                                 stock_dec;

  assign stock_dec = (state_q == VEND) && bus.dispense_ready;

  always_comb begin
    stock_d     = stock_q;
    stock_empty = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (stock_dec && int'(dispense_id_q) == i) stock_d[i] = stock_q[i] - 1'b1;
      if (int'(bus.select) == i && stock_q[i] == '0) stock_empty = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      stock_q <= stock_d;
    end
  end
`else
  assign stock_empty = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      credit_q         <= '0;
      price_q          <= '0;
      coin_reject_q    <= 1'b0;
      sold_out_q       <= 1'b0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= '0;
      change_valid_q   <= 1'b0;
      change_coin_q    <= COIN_5;
      change_val_q     <= '0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      price_q          <= price_d;
      coin_reject_q    <= coin_reject_d;
      sold_out_q       <= sold_out_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      change_valid_q   <= change_valid_d;
      change_coin_q    <= change_coin_d;
      change_val_q     <= change_val_d;
    end
  end

  assign bus.coin_reject    = coin_reject_q;
  assign bus.sold_out       = sold_out_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.dispense_id    = dispense_id_q;
  assign bus.change_valid   = change_valid_q;
  assign bus.change_coin    = change_coin_q;
  assign bus.credit         = credit_q;
  assign bus.price          = price_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios with literal expectations, then random traffic vs a credit-level model.
module tb_vend_ctrl;
  localparam int NP = 4, SW = 4, CW = 8, MAXC = 200;
`ifdef VM_STOCK_EN
  localparam int  SINIT = 1;
  localparam bit  STOCK = 1'b1;
`else
  localparam int  SINIT = 5;
  localparam bit  STOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vend_ctrl_if #(.SEL_W(SW), .CREDIT_W(CW)) bus ();

  vend_ctrl #(
    .NUM_PRODUCTS(NP), .SEL_W(SW), .CREDIT_W(CW), .MAX_CREDIT(MAXC),
    .PRICE_TABLE({8'd125, 8'd100, 8'd75, 8'd50}), .STOCK_W(4), .STOCK_INIT(SINIT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int prices [NP] = '{50, 75, 100, 125};

  function automatic int cval(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  function automatic int gval(input int c);
    return (c >= 25) ? 25 : ((c >= 10) ? 10 : 5);
  endfunction

  function automatic int gcode(input int c);
    return (c >= 25) ? 2 : ((c >= 10) ? 1 : 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: credit plus "vending"/"changing" flags; change coin derived from credit on the fly.
  int m_credit, m_price, m_id;
  int m_stock [NP];
  bit m_vend, m_chg, m_rej, m_sold;

  initial begin : compare
    bit blocked;
    int s;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_credit = 0; m_price = 0; m_id = 0;
        m_vend = 0; m_chg = 0; m_rej = 0; m_sold = 0;
        for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
      end else begin
        m_rej = 0; m_sold = 0;
        if (m_vend) begin
          m_rej = bus.coin_valid;
          if (bus.dispense_ready) begin
            m_credit -= m_price;
            m_stock[m_id]--;
            m_vend = 0;
            m_chg  = (m_credit > 0);
          end
        end else if (m_chg) begin
          m_rej = bus.coin_valid;
          if (bus.change_ready) begin
            m_credit -= gval(m_credit);
            if (m_credit == 0) m_chg = 0;
          end
        end else begin
          blocked = 0;
          s = int'(bus.select);
          if (bus.cancel && m_credit > 0) begin
            m_chg = 1; blocked = 1;
          end else if (bus.select_valid && s < NP) begin
            m_price = prices[s];
            if (STOCK && m_stock[s] == 0) m_sold = 1;
            else if (m_credit >= m_price) begin
              m_vend = 1; m_id = s; blocked = 1;
            end
          end
          if (bus.coin_valid) begin
            if (!blocked && m_credit + cval(int'(bus.coin_type)) <= MAXC)
              m_credit += cval(int'(bus.coin_type));
            else
              m_rej = 1;
          end
        end
      end
      #1;
      chk("cmp_credit", 32'(bus.credit), m_credit);
      chk("cmp_price", 32'(bus.price), m_price);
      chk("cmp_disp_valid", 32'(bus.dispense_valid), 32'(m_vend));
      chk("cmp_disp_id", 32'(bus.dispense_id), m_id);
      chk("cmp_chg_valid", 32'(bus.change_valid), 32'(m_chg));
      chk("cmp_reject", 32'(bus.coin_reject), 32'(m_rej));
      chk("cmp_sold_out", 32'(bus.sold_out), 32'(m_sold));
      if (m_chg) chk("cmp_chg_coin", 32'(bus.change_coin), gcode(m_credit));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_price", 32'(bus.price), 0);
    chk("rst_disp_valid", 32'(bus.dispense_valid), 0);
    chk("rst_chg_valid", 32'(bus.change_valid), 0);
    chk("rst_disp_id", 32'(bus.dispense_id), 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic coin_in(input int t);
    bus.coin_valid = 1'b1; bus.coin_type = 2'(t);
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic sel_in(input int s);
    bus.select_valid = 1'b1; bus.select = SW'(s);
    tick();
    bus.select_valid = 1'b0;
  endtask

  task automatic cancel_in();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  initial begin : stim
    bus.coin_valid = 0; bus.coin_type = 0; bus.select_valid = 0; bus.select = 0;
    bus.cancel = 0; bus.dispense_ready = 0; bus.change_ready = 0;
    tick();
    do_reset();

    // exact-price purchase, no change
    repeat (3) coin_in(2);
    chk("t1_credit", 32'(bus.credit), 75);
    sel_in(1);
    chk("t1_disp_valid", 32'(bus.dispense_valid), 1);
    chk("t1_disp_id", 32'(bus.dispense_id), 1);
    chk("t1_price", 32'(bus.price), 75);
    bus.dispense_ready = 1; tick(); bus.dispense_ready = 0;
    chk("t1_credit_after", 32'(bus.credit), 0);
    chk("t1_no_change", 32'(bus.change_valid), 0);

    // 100c, buy 50c, change 25+25
    do_reset();
    coin_in(3);
    sel_in(0);
    bus.dispense_ready = 1; tick(); bus.dispense_ready = 0;
    chk("t2_credit50", 32'(bus.credit), 50);
    chk("t2_chg_valid", 32'(bus.change_valid), 1);
    chk("t2_coin0", 32'(bus.change_coin), 2);
    bus.change_ready = 1; tick();
    chk("t2_credit25", 32'(bus.credit), 25);
    chk("t2_coin1", 32'(bus.change_coin), 2);
    tick();
    chk("t2_credit0", 32'(bus.credit), 0);
    chk("t2_chg_drop", 32'(bus.change_valid), 0);
    bus.change_ready = 0;

    // ceiling: 190 + 25 rejected, 190 + 10 = 200 accepted
    do_reset();
    coin_in(3); repeat (3) coin_in(2); coin_in(1); coin_in(0);
    chk("t3_credit190", 32'(bus.credit), 190);
    coin_in(2);
    chk("t3_reject", 32'(bus.coin_reject), 1);
    chk("t3_credit_kept", 32'(bus.credit), 190);
    coin_in(1);
    chk("t3_credit200", 32'(bus.credit), 200);
    chk("t3_no_reject", 32'(bus.coin_reject), 0);

    // insufficient credit, then cancel with stalled ejector
    do_reset();
    coin_in(2); coin_in(1); coin_in(0);
    sel_in(3);
    chk("t4_price", 32'(bus.price), 125);
    chk("t4_no_vend", 32'(bus.dispense_valid), 0);
    chk("t4_credit", 32'(bus.credit), 40);
    cancel_in();
    chk("t4_chg_valid", 32'(bus.change_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_coin", 32'(bus.change_coin), 2);
      chk("t4_stall_valid", 32'(bus.change_valid), 1);
    end
    bus.change_ready = 1; tick();
    chk("t4_credit15", 32'(bus.credit), 15);
    chk("t4_coin10", 32'(bus.change_coin), 1);
    tick();
    chk("t4_credit5", 32'(bus.credit), 5);
    chk("t4_coin5", 32'(bus.change_coin), 0);
    tick();
    chk("t4_credit0", 32'(bus.credit), 0);
    chk("t4_chg_drop", 32'(bus.change_valid), 0);
    bus.change_ready = 0;

    // same-cycle coin + successful select: coin rejected
    do_reset();
    coin_in(2); coin_in(2);
    bus.coin_valid = 1; bus.coin_type = 2'd1; bus.select_valid = 1; bus.select = 0;
    tick();
    bus.coin_valid = 0; bus.select_valid = 0;
    chk("t5_vend", 32'(bus.dispense_valid), 1);
    chk("t5_reject", 32'(bus.coin_reject), 1);
    chk("t5_credit", 32'(bus.credit), 50);
    bus.dispense_ready = 1; tick(); bus.dispense_ready = 0;
    chk("t5_credit0", 32'(bus.credit), 0);
    chk("t5_no_change", 32'(bus.change_valid), 0);

    // async reset in the middle of a vend clears outputs at once
    do_reset();
    coin_in(3); sel_in(0);
    chk("t6_vend", 32'(bus.dispense_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vend", 32'(bus.dispense_valid), 0);
    chk("t6_rst_credit", 32'(bus.credit), 0);
    tick();
    rst_n = 1'b1;

    // second purchase of product 2
    do_reset();
    coin_in(3); sel_in(2);
    bus.dispense_ready = 1; tick(); bus.dispense_ready = 0;
    chk("t7_credit0", 32'(bus.credit), 0);
    coin_in(3); sel_in(2);
    chk("t7_price", 32'(bus.price), 100);
    chk("t7_credit", 32'(bus.credit), 100);
`ifdef VM_STOCK_EN
    chk("t7_sold_out", 32'(bus.sold_out), 1);
    chk("t7_no_vend", 32'(bus.dispense_valid), 0);
    tick();
    chk("t7_sold_pulse", 32'(bus.sold_out), 0);
`else
    chk("t7_sold_out", 32'(bus.sold_out), 0);
    chk("t7_vend", 32'(bus.dispense_valid), 1);
`endif

    // random traffic, occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.coin_valid     = ($urandom_range(0, 2) == 0);
      bus.coin_type      = 2'($urandom_range(0, 3));
      bus.select_valid   = ($urandom_range(0, 7) == 0);
      bus.select         = SW'($urandom_range(0, 5));
      bus.cancel         = ($urandom_range(0, 15) == 0);
      bus.dispense_ready = 1'($urandom_range(0, 1));
      bus.change_ready   = 1'($urandom_range(0, 1));
      rst_n              = ($urandom_range(0, 499) != 0);
      tick();
    end
    bus.coin_valid = 0; bus.select_valid = 0; bus.cancel = 0;
    rst_n = 1'b1;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
